// File: rtl/jam_cost_table_pkg.sv
// Shared constants, state encoding and helpers for the job-assignment cost table.
// The assignment engine imports the same COST_W/SUM_W so widths stay consistent.
package jam_cost_table_pkg;

  localparam int NUM_WORKERS = 8;
  localparam int NUM_JOBS    = 8;
  localparam int COST_W      = 7;
  localparam int SUM_W       = 10;
  localparam int IDX_W       = $clog2(NUM_WORKERS);
  localparam int NUM_ENTRIES = NUM_WORKERS * NUM_JOBS;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);

  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                 input logic [COST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_cost_table_mem.sv
// 64x7 cost storage: one write port, one registered read port.
// Contents are deliberately not reset; they are only meaningful once a load completes.
module jam_cost_mem
  import jam_cost_table_pkg::*;
(
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COST_W-1:0] rd_data
);

  logic [COST_W-1:0] mem_reg [NUM_ENTRIES];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/jam_cost_table.sv
// Cost table for the assignment engine: streams in 64 costs row-major, then serves
// one-cycle (W,J) lookups and the sum of per-worker minimum costs as a lower bound.
module jam_cost_table
  import jam_cost_table_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              Reload,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic              TableReady,
  output logic [SUM_W-1:0]  LowerBound
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [COST_W-1:0] row_min_reg, row_min_next;
  logic [SUM_W-1:0]  acc_reg, acc_next;
  logic              cost_en_reg;
  logic              xfer;
  logic [COST_W-1:0] cur_min;
  logic [COST_W-1:0] rd_data;

  // Low counter bits are the job index; the first job of a row restarts the minimum.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    row_min_next = row_min_reg;
    acc_next     = acc_reg;
    in_ready     = (state_reg == LOAD);
    xfer         = 1'b0;
    cur_min      = (cnt_reg[IDX_W-1:0] == '0) ? in_data : cost_min(row_min_reg, in_data);

    if (Reload) begin
      state_next   = LOAD;
      cnt_next     = '0;
      acc_next     = '0;
      row_min_next = COST_MAX;
    end else if (state_reg == LOAD && in_valid) begin
      xfer         = 1'b1;
      cnt_next     = cnt_reg + ADDR_W'(1);
      row_min_next = cur_min;
      if (cnt_reg[IDX_W-1:0] == '1) begin
        acc_next = acc_reg + SUM_W'(cur_min);
      end
      if (cnt_reg == '1) begin
        state_next = READY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= LOAD;
      cnt_reg     <= '0;
      row_min_reg <= COST_MAX;
      acc_reg     <= '0;
      cost_en_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      row_min_reg <= row_min_next;
      acc_reg     <= acc_next;
      // Only lookups sampled while READY (and not being reloaded) may reach Cost.
      cost_en_reg <= (state_reg == READY) && !Reload;
    end
  end

  jam_cost_mem u_mem (
    .CLK     (CLK),
    .wr_en   (xfer && !RST),
    .wr_addr (cnt_reg),
    .wr_data (in_data),
    .rd_addr ({W, J}),
    .rd_data (rd_data)
  );

  assign Cost       = cost_en_reg ? rd_data : '0;
  assign TableReady = (state_reg == READY);
  assign LowerBound = acc_reg;

endmodule
